// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin bus arbiter.
// Contents: FSM state encoding, requester IDs (same encoding as the bus
// select line) and the default burst limit.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Requester IDs double as the value driven on sel for that requester.
    localparam logic REQ_1 = 1'b0;
    localparam logic REQ_2 = 1'b1;

    localparam int MAX_BURST_DEFAULT = 4;

    // The requester that is not the given one; used to pass priority on.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the arbiter's requester and consumer signals.
// Ports (via modports):
//   req_1/data_1/gnt_1, req_2/data_2/gnt_2 : per-requester request, data, grant
//   sel                                    : registered 2:1 bus select
//   out_valid/out_data/out_ready           : downstream valid/ready beat
// master = environment side (producers and consumer), slave = arbiter side.
interface bus_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req_1;
    logic [WIDTH-1:0] data_1;
    logic             gnt_1;
    logic             req_2;
    logic [WIDTH-1:0] data_2;
    logic             gnt_2;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output req_1, data_1, req_2, data_2, out_ready,
        input  gnt_1, gnt_2, sel, out_valid, out_data
    );

    modport slave (
        input  req_1, data_1, req_2, data_2, out_ready,
        output gnt_1, gnt_2, sel, out_valid, out_data
    );
endinterface

// File: rtl/bus_arbiter_arb_rr_pick.sv
// Combinational round-robin pick between two requesters.
// Ports:
//   req_1, req_2 : request lines
//   ptr          : requester that wins when both request
//   winner       : chosen requester ID (REQ_1 / REQ_2)
//   any_req      : at least one requester is asking
module arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic req_1,
    input  logic req_2,
    input  logic ptr,
    output logic winner,
    output logic any_req
);

    // Lone requester wins outright; on a tie the priority pointer decides.
    always_comb begin
        winner  = REQ_1;
        any_req = req_1 | req_2;
        if (req_1 && req_2) begin
            winner = ptr;
        end else if (req_2) begin
            winner = REQ_2;
        end else begin
            winner = REQ_1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter sharing one WIDTH-bit output bus.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bus_arbiter_if.slave (requests, data, grants, sel, valid/ready out)
// A grant lasts until the owner drops its request or MAX_BURST beats have
// been accepted; every release passes through one IDLE cycle and hands the
// tie-break priority to the other requester.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_if.slave   bus
);

    localparam int             CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    state_t          state_r, state_s;
    logic            gnt_1_r, gnt_1_s;
    logic            gnt_2_r, gnt_2_s;
    logic            sel_r,   sel_s;
    logic            ptr_r,   ptr_s;
    logic [CW-1:0]   cnt_r,   cnt_s;

    logic            winner_s;
    logic            any_req_s;
    logic            owner_req_s;
    logic            valid_s;
    logic            beat_s;

    arb_rr_pick u_pick (
        .req_1   (bus.req_1),
        .req_2   (bus.req_2),
        .ptr     (ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // sel tracks the owner throughout GRANT, so it also selects the owner's request.
    assign owner_req_s = (sel_r == REQ_2) ? bus.req_2 : bus.req_1;
    assign valid_s     = (gnt_1_r & bus.req_1) | (gnt_2_r & bus.req_2);
    assign beat_s      = valid_s & bus.out_ready;

    assign bus.gnt_1     = gnt_1_r;
    assign bus.gnt_2     = gnt_2_r;
    assign bus.sel       = sel_r;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = sel_r ? bus.data_2 : bus.data_1;

    // Next-state, grant, select, pointer and burst-counter logic.
    always_comb begin
        state_s = state_r;
        gnt_1_s = gnt_1_r;
        gnt_2_s = gnt_2_r;
        sel_s   = sel_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = GRANT;
                    sel_s   = winner_s;
                    gnt_1_s = (winner_s == REQ_1);
                    gnt_2_s = (winner_s == REQ_2);
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                // Release when the owner is done or its last allowed beat goes out.
                if (!owner_req_s || (beat_s && (cnt_r == LAST_BEAT))) begin
                    state_s = IDLE;
                    gnt_1_s = 1'b0;
                    gnt_2_s = 1'b0;
                    cnt_s   = CNT_ZERO;
                    ptr_s   = other_req(sel_r);
                end else if (beat_s) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_1_s = 1'b0;
                gnt_2_s = 1'b0;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_1_r <= 1'b0;
            gnt_2_r <= 1'b0;
            sel_r   <= REQ_1;
            ptr_r   <= REQ_1;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            gnt_1_r <= gnt_1_s;
            gnt_2_r <= gnt_2_s;
            sel_r   <= sel_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule
